// File: rtl/lift_call_panel.sv
// lift_call_panel
// Debounces the eight floor-call buttons, keeps one lit lamp per pending call,
// and hands pending calls to the lift controller one at a time over a
// valid/ready handshake. A lamp goes out when the car stands at that floor
// with the door open.
module lift_call_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] btn,
  input  logic [2:0] current_floor,
  input  logic       door,
  input  logic       emergency_stop,
  input  logic       req_ready,
  output logic [2:0] req_floor,
  output logic       req_valid,
  output logic [7:0] lamp,
  output logic [3:0] pending_count
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       samp_q, samp_d;
  logic [7:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic [7:0]       press;
  logic [7:0]       clear_mask;
  logic [7:0]       lamp_q, lamp_d;
  logic [7:0]       issued_q, issued_d;
  logic [7:0]       issued_set;
  logic [7:0]       cand;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [2:0]       scan_idx;
  logic [2:0]       sel_floor;
  logic             sel_found;
  logic [1:0]       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [2:0]       req_floor_q, req_floor_d;
  logic             req_valid_q, req_valid_d;

  // Sampling tick, debounce filter and the lamp set/clear rule (clear wins).
  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    samp_d   = tick ? sync2_q : samp_q;
    stable_d = stable_q;
    if (tick) begin
      stable_d = (sync2_q & ~(sync2_q ^ samp_q)) | (stable_q & (sync2_q ^ samp_q));
    end
    press      = stable_d & ~stable_q;
    clear_mask = door ? (8'd1 << current_floor) : 8'd0;
    lamp_d     = (lamp_q | press) & ~clear_mask;
  end

  // Round-robin pick of the first lit, not-yet-sent floor starting at rr_ptr.
  always_comb begin
    cand      = lamp_q & ~issued_q;
    sel_found = 1'b0;
    sel_floor = rr_ptr_q;
    scan_idx  = '0;
    for (int k = 0; k < 8; k++) begin
      scan_idx = rr_ptr_q + 3'(k);
      if (!sel_found && cand[scan_idx]) begin
        sel_found = 1'b1;
        sel_floor = scan_idx;
      end
    end
  end

  // Request FSM: launch a call, hold it until accepted, then rest for the gap.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    req_floor_d = req_floor_q;
    req_valid_d = req_valid_q;
    rr_ptr_d    = rr_ptr_q;
    issued_set  = '0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found && !emergency_stop) begin
          req_floor_d = sel_floor;
          req_valid_d = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          issued_set  = 8'd1 << req_floor_q;
          rr_ptr_d    = req_floor_q + 3'd1;
          gap_d       = '0;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_MAX) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        req_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    // A call only stays marked as sent while its lamp survives this cycle.
    issued_d = (issued_q | issued_set) & lamp_d;
  end

  // All state registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      samp_q      <= '0;
      stable_q    <= '0;
      cnt_q       <= '0;
      lamp_q      <= '0;
      issued_q    <= '0;
      rr_ptr_q    <= '0;
      state_q     <= ST_IDLE;
      gap_q       <= '0;
      req_floor_q <= '0;
      req_valid_q <= 1'b0;
    end else begin
      sync1_q     <= btn;
      sync2_q     <= sync1_q;
      samp_q      <= samp_d;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      lamp_q      <= lamp_d;
      issued_q    <= issued_d;
      rr_ptr_q    <= rr_ptr_d;
      state_q     <= state_d;
      gap_q       <= gap_d;
      req_floor_q <= req_floor_d;
      req_valid_q <= req_valid_d;
    end
  end

  // Number of lit lamps, straight from the lamp register.
  always_comb begin
    pending_count = '0;
    for (int i = 0; i < 8; i++) begin
      pending_count = pending_count + {3'b000, lamp_q[i]};
    end
  end

  assign req_floor = req_floor_q;
  assign req_valid = req_valid_q;
  assign lamp      = lamp_q;

endmodule

// File: tb/tb_lift_call_panel.sv
// tb_lift_call_panel
// Randomised bench for the call panel: stimulus pushes the expected request
// order into a queue from a set-based model of lamps, a monitor pops and
// compares on every accepted request.
module tb_lift_call_panel;

   localparam int DEB = 4;
   localparam int GAP = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] btn;
   logic [2:0] currentFloor;
   logic       door;
   logic       emergencyStop;
   logic       reqReady;
   logic [2:0] reqFloor;
   logic       reqValid;
   logic [7:0] lamp;
   logic [3:0] pendingCount;

   int testsRun = 0;
   int testsFailed = 0;
   int expQ[$];
   int riseQ[$];
   int cycleNo = 0;
   int readyMode = 1;

   logic [7:0] lampM;
   logic [7:0] issuedM;
   int         ptrM;

   logic       prevValid = 1'b0;
   logic [2:0] prevFloor = 3'd0;
   logic       prevAcc = 1'b0;
   logic       prevReset = 1'b0;

   lift_call_panel #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP)) dut (
      .clk(clk),
      .reset(reset),
      .btn(btn),
      .current_floor(currentFloor),
      .door(door),
      .emergency_stop(emergencyStop),
      .req_ready(reqReady),
      .req_floor(reqFloor),
      .req_valid(reqValid),
      .lamp(lamp),
      .pending_count(pendingCount)
   );

   // Free-running clock and a cycle counter used to time request rises.
   always #5 clk = ~clk;

   always @(posedge clk) cycleNo <= cycleNo + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic failNow(input string name);
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s", name);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: lamps and sent calls as plain sets, round-robin order.
   task automatic modelReset();
      lampM = 8'h00;
      issuedM = 8'h00;
      ptrM = 0;
   endtask

   task automatic modelPress(input logic [7:0] m);
      lampM = lampM | m;
   endtask

   task automatic modelIssueAll();
      int f;
      int last;
      bit any;
      any = 0;
      last = 0;
      for (int k = 0; k < 8; k++) begin
         f = (ptrM + k) % 8;
         if (lampM[f] && !issuedM[f]) begin
            expQ.push_back(f);
            issuedM[f] = 1'b1;
            last = f;
            any = 1;
         end
      end
      if (any) ptrM = (last + 1) % 8;
   endtask

   task automatic checkLamps(input string name);
      @(negedge clk);
      checkOutput({name, " lamp"}, int'(lamp), int'(lampM));
      checkOutput({name, " pending_count"}, int'(pendingCount), $countones(lampM));
   endtask

   task automatic applyStimulus(input logic [7:0] mask, input int hold);
      btn = mask;
      cycles(hold);
      btn = 8'h00;
   endtask

   task automatic serviceFloor(input int f);
      currentFloor = 3'(f);
      door = 1'b1;
      cycles(1);
      door = 1'b0;
      lampM[f] = 1'b0;
      issuedM[f] = 1'b0;
      checkLamps("service");
   endtask

   task automatic serviceAll();
      for (int f = 0; f < 8; f++) begin
         if (lampM[f]) serviceFloor(f);
      end
   endtask

   task automatic waitDrain();
      int t;
      t = 0;
      while (expQ.size() != 0 && t < 600) begin
         @(posedge clk);
         t++;
      end
      if (expQ.size() != 0) begin
         failNow("drain timeout");
         expQ.delete();
      end
      cycles(4);
   endtask

   task automatic waitValid(input string name);
      int t;
      t = 0;
      @(negedge clk);
      while (!reqValid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!reqValid) failNow({name, " req_valid timeout"});
   endtask

   // Controller side: req_ready random, forced low or forced high.
   initial begin
      reqReady = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            0: reqReady = ($urandom_range(0, 2) != 0);
            1: reqReady = 1'b0;
            default: reqReady = 1'b1;
         endcase
      end
   end

   // Monitor: handshake scoreboard plus hold-stable and one-cycle-drop checks.
   initial begin
      forever begin
         @(negedge clk);
         if (prevValid && !prevAcc && !prevReset) begin
            checkOutput("valid held", int'(reqValid), 1);
            checkOutput("floor held", int'(reqFloor), int'(prevFloor));
         end
         if (prevAcc && !prevReset) checkOutput("valid drop after handshake", int'(reqValid), 0);
         if (reqValid && !prevValid) riseQ.push_back(cycleNo);
         if (reqValid && reqReady && !reset) begin
            if (expQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpected request: got floor %0d, expected none", reqFloor);
            end else begin
               checkOutput("request floor", int'(reqFloor), expQ.pop_front());
            end
         end
         prevValid = reqValid;
         prevFloor = reqFloor;
         prevAcc = reqValid && reqReady;
         prevReset = reset;
      end
   end

   // Directed phases followed by random batches.
   initial begin
      logic [7:0] mask;
      reset = 1'b1;
      btn = 8'hFF;
      currentFloor = 3'd0;
      door = 1'b0;
      emergencyStop = 1'b0;
      readyMode = 1;
      modelReset();

      // Reset values while buttons are all held.
      repeat (2) begin
         @(negedge clk);
         checkOutput("reset req_valid", int'(reqValid), 0);
         checkOutput("reset req_floor", int'(reqFloor), 0);
         checkOutput("reset lamp", int'(lamp), 0);
         checkOutput("reset pending_count", int'(pendingCount), 0);
      end
      modelPress(8'hFF);
      modelIssueAll();
      readyMode = 0;
      reset = 1'b0;
      repeat (2 * DEB - 1) @(posedge clk);
      @(negedge clk);
      checkOutput("lamp early after reset", int'(lamp), 0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("lamp after debounce", int'(lamp), 8'hFF);
      waitDrain();
      btn = 8'h00;
      cycles(2 * DEB + 4);
      serviceAll();

      // Debounce: glitch rejected, long hold accepted and requested.
      readyMode = 2;
      applyStimulus(8'h20, 3);
      cycles(2 * DEB + 6);
      checkLamps("glitch");
      modelPress(8'h20);
      modelIssueAll();
      btn = 8'h20;
      repeat (11) @(posedge clk);
      @(negedge clk);
      checkOutput("hold lamp", int'(lamp), 8'h20);
      cycles(1);
      btn = 8'h00;
      waitDrain();
      cycles(2 * DEB + 4);
      serviceAll();

      // Round-robin and handshake from a freshly reset pointer.
      cycles(1);
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
      modelReset();
      checkLamps("post reset");
      readyMode = 1;
      modelPress(8'hC4);
      modelIssueAll();
      riseQ.delete();
      btn = 8'hC4;
      waitValid("rr first");
      checkOutput("rr first floor", int'(reqFloor), 2);
      cycles(5);
      @(negedge clk);
      checkOutput("rr held valid", int'(reqValid), 1);
      checkOutput("rr held floor", int'(reqFloor), 2);
      readyMode = 2;
      btn = 8'h00;
      waitDrain();
      if (riseQ.size() >= 3) checkOutput("back-to-back spacing", riseQ[2] - riseQ[1], 2 + GAP);
      else failNow("too few request rises");
      cycles(20);
      checkLamps("no reissue");
      serviceAll();

      // Service clear, relight, and clear-wins with the door open.
      readyMode = 0;
      repeat (2) begin
         modelPress(8'h08);
         modelIssueAll();
         applyStimulus(8'h08, 12);
         waitDrain();
         cycles(2 * DEB + 4);
         serviceFloor(3);
      end
      currentFloor = 3'd3;
      door = 1'b1;
      applyStimulus(8'h08, 12);
      cycles(2 * DEB + 4);
      checkLamps("clear wins");
      door = 1'b0;
      cycles(4);
      checkLamps("clear wins after door");

      // Random batches with random controller readiness and random service.
      for (int b = 0; b < 6; b++) begin
         mask = 8'($urandom_range(1, 255));
         modelPress(mask);
         modelIssueAll();
         applyStimulus(mask, 12);
         waitDrain();
         cycles(2 * DEB + 4);
         checkLamps("batch");
         for (int f = 0; f < 8; f++) begin
            if (lampM[f] && ($urandom_range(0, 1) == 1)) serviceFloor(f);
         end
      end
      serviceAll();

      // Emergency stop holds requests but keeps lamps working.
      emergencyStop = 1'b1;
      modelPress(8'h12);
      applyStimulus(8'h12, 12);
      cycles(2 * DEB + 4);
      checkLamps("estop");
      repeat (5) begin
         @(negedge clk);
         checkOutput("estop no valid", int'(reqValid), 0);
      end
      modelIssueAll();
      emergencyStop = 1'b0;
      waitDrain();
      serviceAll();

      // Emergency stop raised mid-SEND does not drop the request.
      readyMode = 1;
      modelPress(8'h40);
      modelIssueAll();
      btn = 8'h40;
      waitValid("estop send");
      emergencyStop = 1'b1;
      cycles(3);
      @(negedge clk);
      checkOutput("estop send valid", int'(reqValid), 1);
      readyMode = 2;
      btn = 8'h00;
      waitDrain();
      emergencyStop = 1'b0;
      cycles(2 * DEB + 4);
      serviceAll();

      // Reset while in SEND, then search restarts at floor 0.
      readyMode = 1;
      modelPress(8'h64);
      btn = 8'h64;
      waitValid("reset send");
      btn = 8'h00;
      cycles(1);
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      modelReset();
      @(negedge clk);
      checkOutput("reset send req_valid", int'(reqValid), 0);
      checkOutput("reset send lamp", int'(lamp), 0);
      readyMode = 0;
      modelPress(8'hA0);
      modelIssueAll();
      applyStimulus(8'hA0, 12);
      waitDrain();
      cycles(2 * DEB + 4);
      checkLamps("after reset");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
